// File: rtl/dff_check_pkg.sv
// Shared definitions for the D flip-flop checker: FSM state codes, the
// default counter width and the reference rule for the flip-flop's next Q.
package dff_check_pkg;

  localparam int DEFAULT_CNT_W = 16;

  // Checker states: INIT = model not loaded, RUN = comparing every
  // enabled edge, HALT = frozen after a failure until reset
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Next Q of a synchronous flip-flop where reset has priority over preset
  function automatic logic model_next(input logic d, input logic rst, input logic pre);
    logic nxt;
    if (rst) begin
      nxt = 1'b0;
    end else if (pre) begin
      nxt = 1'b1;
    end else begin
      nxt = d;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping,
// so long soak runs never report a misleadingly small count.
module sat_counter
  import dff_check_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count enabled events, holding once every bit is set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/dff_sync_checker.sv
// Self-checking monitor for a synchronous D flip-flop with reset and preset.
// It samples the same D/reset/preset the flip-flop sees, keeps a model of Q
// and compares the flip-flop's Q one edge later.
// Optional build macro DFF_CHECK_QN_EN: also fail a check when dut_qn is not
// the complement of dut_q; without it dut_qn is ignored.
module dff_sync_checker
  import dff_check_pkg::*;
#(
  parameter int CNT_W        = DEFAULT_CNT_W,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dut_d,
  input  logic             dut_reset,
  input  logic             dut_preset,
  input  logic             dut_q,
  input  logic             dut_qn,
  output logic             exp_q,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] first_fail
);

  logic [1:0] state;
  logic       model_d;
  logic       bad;
  logic       check_en;
  logic       error_en;

  assign model_d = model_next(dut_d, dut_reset, dut_preset);

`ifdef DFF_CHECK_QN_EN
  assign bad = (dut_q != exp_q) || (dut_qn == dut_q);
`else
  logic unused_qn;
  assign unused_qn = dut_qn;
  assign bad       = (dut_q != exp_q);
`endif

  // A check happens only on an enabled edge while the model is valid
  assign check_en = enable && (state == ST_RUN);
  assign error_en = check_en && bad;

  sat_counter #(.CNT_W(CNT_W)) u_check_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (check_en),
    .count (check_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_error_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (error_en),
    .count (error_count)
  );

  // Model load, compare bookkeeping and INIT/RUN/HALT sequencing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      exp_q      <= 1'b0;
      mismatch   <= 1'b0;
      fail       <= 1'b0;
      first_fail <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        ST_INIT: begin
          if (enable) begin
            exp_q <= model_d;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_INIT;
          end else begin
            exp_q <= model_d;
            if (bad) begin
              mismatch <= 1'b1;
              fail     <= 1'b1;
              if (!fail) begin
                first_fail <= check_count;
              end
              if (STOP_ON_FAIL) begin
                state <= ST_HALT;
              end
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_sync_checker.sv
// Randomised scoreboard bench for dff_sync_checker. Three checkers watch one
// behavioural flip-flop: default build, stop-on-fail, and a 4-bit counter
// build. Each checker's Q/_Q can be corrupted independently.
module tb_dff_sync_checker;

  typedef struct {
    int expq;
    int mism;
    int fail;
    int cc;
    int ec;
    int ff;
  } rec_t;

`ifdef DFF_CHECK_QN_EN
  localparam bit QN_CHK = 1'b1;
`else
  localparam bit QN_CHK = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic enable;
  logic dut_d;
  logic dut_reset;
  logic dut_preset;
  logic ffq;
  logic [2:0] qfault;
  logic [2:0] qnfault;
  logic [2:0] dq;
  logic [2:0] dqn;

  logic [2:0] expq;
  logic [2:0] mism;
  logic [2:0] failo;
  logic [15:0] cc0, ec0, ff0, cc1, ec1, ff1;
  logic [3:0]  cc2, ec2, ff2;

  int tests = 0;
  int failures = 0;

  rec_t sb0[$];
  rec_t sb1[$];
  rec_t sb2[$];

  // Reference model state, one slot per checker
  int   mcc[3];
  int   mec[3];
  int   mff[3];
  bit   mloaded[3];
  bit   mhalt[3];
  bit   mfail[3];
  logic mexpq[3];
  logic mq;
  int   cmax[3]  = '{65535, 65535, 15};
  bit   stopc[3] = '{1'b0, 1'b1, 1'b0};

  // The flip-flop under observation, behaving correctly
  always @(posedge clock) begin
    ffq <= dut_reset ? 1'b0 : (dut_preset ? 1'b1 : dut_d);
  end

  for (genvar g = 0; g < 3; g++) begin : g_faults
    assign dq[g]  = ffq ^ qfault[g];
    assign dqn[g] = qnfault[g] ? dq[g] : ~dq[g];
  end

  dff_sync_checker u_def (
    .clock(clock), .reset(reset), .enable(enable), .dut_d(dut_d),
    .dut_reset(dut_reset), .dut_preset(dut_preset), .dut_q(dq[0]), .dut_qn(dqn[0]),
    .exp_q(expq[0]), .mismatch(mism[0]), .fail(failo[0]),
    .check_count(cc0), .error_count(ec0), .first_fail(ff0)
  );

  dff_sync_checker #(.STOP_ON_FAIL(1'b1)) u_stop (
    .clock(clock), .reset(reset), .enable(enable), .dut_d(dut_d),
    .dut_reset(dut_reset), .dut_preset(dut_preset), .dut_q(dq[1]), .dut_qn(dqn[1]),
    .exp_q(expq[1]), .mismatch(mism[1]), .fail(failo[1]),
    .check_count(cc1), .error_count(ec1), .first_fail(ff1)
  );

  dff_sync_checker #(.CNT_W(4)) u_small (
    .clock(clock), .reset(reset), .enable(enable), .dut_d(dut_d),
    .dut_reset(dut_reset), .dut_preset(dut_preset), .dut_q(dq[2]), .dut_qn(dqn[2]),
    .exp_q(expq[2]), .mismatch(mism[2]), .fail(failo[2]),
    .check_count(cc2), .error_count(ec2), .first_fail(ff2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic checkRec(input string tag, input rec_t e, input logic aq, input logic am,
                          input logic af, input logic [31:0] acc, input logic [31:0] aec,
                          input logic [31:0] aff);
    checkOutput({tag, ".exp_q"},       {31'b0, aq}, e.expq);
    checkOutput({tag, ".mismatch"},    {31'b0, am}, e.mism);
    checkOutput({tag, ".fail"},        {31'b0, af}, e.fail);
    checkOutput({tag, ".check_count"}, acc, e.cc);
    checkOutput({tag, ".error_count"}, aec, e.ec);
    checkOutput({tag, ".first_fail"},  aff, e.ff);
  endtask

  // Monitor: every edge that had stimulus queued, compare all three checkers
  always @(posedge clock) begin
    rec_t e;
    #1;
    if (sb0.size() > 0 && sb1.size() > 0 && sb2.size() > 0) begin
      e = sb0.pop_front();
      checkRec("def", e, expq[0], mism[0], failo[0], {16'b0, cc0}, {16'b0, ec0}, {16'b0, ff0});
      e = sb1.pop_front();
      checkRec("stop", e, expq[1], mism[1], failo[1], {16'b0, cc1}, {16'b0, ec1}, {16'b0, ff1});
      e = sb2.pop_front();
      checkRec("small", e, expq[2], mism[2], failo[2], {28'b0, cc2}, {28'b0, ec2}, {28'b0, ff2});
    end
  end

  // Drive one edge's inputs and predict every checker's outputs after that edge
  task automatic applyStimulus(input logic en, input logic d, input logic r, input logic p,
                               input logic [2:0] qf, input logic [2:0] qnf);
    rec_t e;
    logic nxt;
    logic qseen;
    logic qnseen;
    bit   bad;
    @(negedge clock);
    enable = en; dut_d = d; dut_reset = r; dut_preset = p;
    qfault = qf; qnfault = qnf;
    nxt = r ? 1'b0 : (p ? 1'b1 : d);
    for (int i = 0; i < 3; i++) begin
      qseen  = mq ^ qf[i];
      qnseen = qnf[i] ? qseen : ~qseen;
      e.mism = 0;
      if (!mhalt[i]) begin
        if (!en) begin
          mloaded[i] = 1'b0;
        end else begin
          if (mloaded[i]) begin
            bad = (qseen != mexpq[i]) || (QN_CHK && (qnseen == qseen));
            if (bad) begin
              e.mism = 1;
              if (!mfail[i]) mff[i] = mcc[i];
              mfail[i] = 1'b1;
              mec[i] = (mec[i] < cmax[i]) ? mec[i] + 1 : mec[i];
              if (stopc[i]) mhalt[i] = 1'b1;
            end
            mcc[i] = (mcc[i] < cmax[i]) ? mcc[i] + 1 : mcc[i];
          end
          mexpq[i]   = nxt;
          mloaded[i] = 1'b1;
        end
      end
      e.expq = {31'b0, mexpq[i]};
      e.fail = {31'b0, mfail[i]};
      e.cc = mcc[i];
      e.ec = mec[i];
      e.ff = mff[i];
      case (i)
        0: sb0.push_back(e);
        1: sb1.push_back(e);
        default: sb2.push_back(e);
      endcase
    end
    mq = nxt;
  endtask

  // Assert the checker reset between clock edges and confirm it clears at once
  task automatic applyReset();
    @(posedge clock);
    #3;
    reset = 1'b0; enable = 1'b0; dut_reset = 1'b1; dut_preset = 1'b0; dut_d = 1'b0;
    qfault = '0; qnfault = '0;
    for (int i = 0; i < 3; i++) begin
      mcc[i] = 0; mec[i] = 0; mff[i] = 0;
      mloaded[i] = 1'b0; mhalt[i] = 1'b0; mfail[i] = 1'b0; mexpq[i] = 1'b0;
    end
    mq = 1'b0;
    #1;
    checkOutput("rst.exp_q", {29'b0, expq}, 32'd0);
    checkOutput("rst.mismatch", {29'b0, mism}, 32'd0);
    checkOutput("rst.fail", {29'b0, failo}, 32'd0);
    checkOutput("rst.check_count", {cc0, cc1}, 32'd0);
    checkOutput("rst.error_count", {ec0, ec1}, 32'd0);
    checkOutput("rst.first_fail", {ff0, ff1}, 32'd0);
    checkOutput("rst.small_counts", {20'b0, cc2, ec2, ff2}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; dut_d = 1'b0; dut_reset = 1'b1; dut_preset = 1'b0;
    qfault = '0; qnfault = '0;
    applyReset();

    // Toggle D on a correct flip-flop for 50 edges
    for (int k = 0; k < 50; k++) applyStimulus(1'b1, k[0], 1'b0, 1'b0, 3'b000, 3'b000);
    settle();
    checkOutput("toggle.check_count", {16'b0, cc0}, 32'd49);
    checkOutput("toggle.error_count", {16'b0, ec0}, 32'd0);
    checkOutput("toggle.fail", {31'b0, failo[0]}, 32'd0);
    checkOutput("toggle.small_sat", {28'b0, cc2}, 32'd15);

    // Reset and preset together: expected Q is 0, then force a wrong Q
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000);
    settle();
    checkOutput("rp.mismatch_pulse", {31'b0, mism[0]}, 32'd1);
    checkOutput("rp.error_count", {16'b0, ec0}, 32'd1);
    checkOutput("rp.first_fail", {16'b0, ff0}, 32'd52);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    settle();
    checkOutput("rp.mismatch_drop", {31'b0, mism[0]}, 32'd0);
    checkOutput("rp.fail_sticky", {31'b0, failo[0]}, 32'd1);

    // Stop-on-fail: fault on the tenth check, then 20 more edges
    applyReset();
    for (int k = 0; k < 11; k++)
      applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, (k == 10) ? 3'b111 : 3'b000, 3'b000);
    for (int k = 0; k < 20; k++)
      applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 3'b000, 3'b000);
    settle();
    checkOutput("halt.check_count", {16'b0, cc1}, 32'd10);
    checkOutput("halt.error_count", {16'b0, ec1}, 32'd1);
    checkOutput("halt.first_fail", {16'b0, ff1}, 32'd9);
    checkOutput("halt.def_count", {16'b0, cc0}, 32'd30);

    // Error counter saturation on the 4-bit build
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    for (int k = 0; k < 20; k++)
      applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 3'b111, 3'b000);
    settle();
    checkOutput("sat.small_errors", {28'b0, ec2}, 32'd15);
    checkOutput("sat.def_errors", {16'b0, ec0}, 32'd20);
    checkOutput("sat.small_first", {28'b0, ff2}, 32'd0);

    // Enable dropped for 3 edges: first edge back only reloads the model
    applyReset();
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 3'b000, 3'b000);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0, 3'b111, 3'b000);
    applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 3'b111, 3'b000);
    applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 3'b000, 3'b000);
    applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 3'b001, 3'b000);
    settle();
    checkOutput("gap.check_count", {16'b0, cc0}, 32'd7);
    checkOutput("gap.error_count", {16'b0, ec0}, 32'd1);
    checkOutput("gap.first_fail", {16'b0, ff0}, 32'd6);

    // _Q driven equal to Q
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 3'b000, 3'b111);
    settle();
    checkOutput("qn.error_count", {16'b0, ec0}, QN_CHK ? 32'd5 : 32'd0);

    // Random soak with occasional faults and enable gaps, then a mid-run reset
    applyReset();
    for (int k = 0; k < 400; k++) begin
      logic [2:0] qf;
      logic [2:0] qnf;
      for (int j = 0; j < 3; j++) begin
        qf[j]  = ($urandom_range(0, 19) == 0);
        qnf[j] = ($urandom_range(0, 29) == 0);
      end
      applyStimulus($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 5) == 0, qf, qnf);
    end
    applyReset();
    settle();
    checkOutput("drain.queue", sb0.size() + sb1.size() + sb2.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/dff_sync_checker.md
# dff_sync_checker

Synthesizable self-checking monitor for the synchronous D flip-flop with reset and preset: the receiving end of the flip-flop stimulus path. It samples the same D/reset/preset inputs the flip-flop sees on each clock edge, keeps a reference model of Q, and compares the flip-flop's Q and _Q on the following edge. It reports per-cycle mismatches, a sticky fail flag and saturating counters. It sits beside the flip-flop in benches and on-board test harnesses.

## Interface
- CNT_W, 16, width of all counters
- STOP_ON_FAIL, 0, 1 = freeze checking after first mismatch
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; checker's own reset
- enable  in  1  1 = sample and check this edge
- dut_d  in  1  D input driven to flip-flop
- dut_reset  in  1  flip-flop synchronous reset, active-high
- dut_preset  in  1  flip-flop synchronous preset, active-high
- dut_q  in  1  flip-flop Q
- dut_qn  in  1  flip-flop _Q
- exp_q  out  1  model's expected Q
- mismatch  out  1  one-cycle pulse on failed check
- fail  out  1  sticky, set on first mismatch
- check_count  out  CNT_W  checks performed
- error_count  out  CNT_W  mismatches seen
- first_fail  out  CNT_W  check_count value at first mismatch

## Operation
- Model next value on each enabled edge: dut_reset ? 0 : dut_preset ? 1 : dut_d (reset beats preset).
- States:
  - INIT: model invalid, no compare. Enabled edge loads model; go to RUN.
  - RUN: each enabled edge compares dut_q to exp_q, then increments check_count and loads the new model.
  - HALT: compare, count and model update stop; outputs hold. Exit only via reset.
- enable low at any edge: no compare, no count; state returns to INIT (the flip-flop keeps clocking, so the model is stale).
- Mismatch in RUN:
  - mismatch=1 for one cycle; error_count+1; fail set.
  - On the first mismatch only, first_fail captures check_count before increment.
  - If STOP_ON_FAIL=1, go to HALT.
- Counters saturate at all-ones and never wrap.
- Reset mid-run: all state cleared immediately, independent of clock.

## Timing
- Reset values: exp_q=0, mismatch=0, fail=0, all counters 0, state INIT.
- Stimulus applied before edge k is captured by the flip-flop and the model at edge k. Q is compared at edge k+1. mismatch is registered at edge k+1 and visible for the cycle after it.
- Latency from first enabled edge to first compare: 1 edge.
- Reset deassertion is synchronized by the surrounding reset scheme. The first edge after release is treated as ordinary.
- dut_reset and dut_preset both high: expected Q=0.

## Configuration
- DFF_CHECK_QN_EN defined: a check also fails if dut_qn != ~dut_q (OR-ed into the mismatch condition).
- Undefined: dut_qn is ignored and its port stays present but unused.

## Structure
- Package dff_check_pkg holds:
  - state enum (INIT, RUN, HALT)
  - default CNT_W
  - model next-value function
- One sub-module, sat_counter (CNT_W-bit increment-enable, saturating), instanced for check_count and error_count.

## Test plan
- Reset low, then high; enable=1; toggle dut_d every cycle on a correct flip-flop for 50 edges -> check_count=49, error_count=0, fail=0.
- dut_reset=1 and dut_preset=1 together for one edge; flip-flop outputs 0 -> no mismatch; force dut_q=1 instead -> mismatch pulse one cycle after the next edge, error_count=1, first_fail equals the check index.
- STOP_ON_FAIL=1, inject a Q fault at check 10 -> HALT; counters frozen at check_count=10 and error_count=1 through 20 further edges.
- Run error injection past 2^CNT_W with CNT_W=4 -> error_count holds 15.
- Drop enable for 3 edges mid-run, then raise it -> first enabled edge does not compare (INIT); comparing resumes on the following edge.
- With DFF_CHECK_QN_EN, drive dut_qn = dut_q -> mismatch on every check. Without the macro -> no mismatch.
